apb_pwm_width_array: RTL
========================

Name: apb_pwm_width_array

Overview:
- APB3 slave that measures pulse-high width, in PCLK cycles, on NUM_CH independent PWM sensor inputs (distance sensors, echo sensors).
- Parametrised successor of the single-channel distance peripheral. Measures by edge detection, not fixed windows.
- Adds per-channel new-data/timeout flags, a programmable timeout, a channel enable mask and error responses on bad addresses.
- Sits on the APB3 bus beside the other sensor peripherals; firmware polls it or reads it on a timer.

Parameters:
- NUM_CH, 4, number of PWM input channels (1..16).
- CNT_W, 24, width of each pulse-width counter/result.
- DEF_TIMEOUT, 2500000, reset value of the TIMEOUT register (cycles); also the maximum accepted high time.

Ports:
- PCLK  in  1  clock
- PRESERN  in  1  reset, synchronous, active-low
- PSEL  in  1  peripheral select
- PENABLE  in  1  access phase
- PWRITE  in  1  1=write, 0=read
- PADDR  in  32  address; bits [11:0] decoded
- PWDATA  in  32  write data
- PRDATA  out  32  read data, combinational from registers
- PREADY  out  1  tied 1 (zero wait states)
- PSLVERR  out  1  error on unmapped access
- sensor_pwm  in  NUM_CH  asynchronous PWM inputs

Behaviour:
- Reset and clocking:
  - One clock; reset is synchronous and active-low: all state clears on the PCLK edge where PRESERN=0.
  - Reset values: results=0, STATUS=0, CTRL=0, TIMEOUT=DEF_TIMEOUT, PRDATA=0, PSLVERR=0.
- Register map, word offsets:
  - 0x000 CTRL RW: [NUM_CH-1:0] channel enable.
  - 0x004 STATUS R/W1C: [NUM_CH-1:0] new_data, [16+NUM_CH-1:16] timeout.
  - 0x008 TIMEOUT RW: [CNT_W-1:0].
  - 0x100+4*ch RESULT RO: [CNT_W-1:0] last width, zero-extended.
- APB access:
  - A write commits when PSEL & PENABLE & PWRITE.
  - A read returns data when PSEL & !PWRITE.
  - Any other offset, or a write to a RESULT address: PSLVERR=1 during the access phase. Writes are ignored; reads return 0.
- Read side effect: reading RESULT[ch] in the access phase clears new_data[ch] on the same edge.
  - If a new result latches on that same edge, set wins: new_data stays 1 and the register takes the new value.
  - The read returns the old value.
- Input sync: each sensor_pwm bit passes through a 2-FF synchroniser.
  - A rising or falling edge is detected from the synchronised bit against its previous value.
  - Input-to-detect latency is 3 cycles.
- Per-channel FSM:
  - WAIT_LOW: enabled; leave when the synced input is 0, go to ARMED. This guarantees a partial pulse present at enable is never measured.
  - ARMED: on a rising edge, go to HIGH with cnt=1.
  - HIGH: cnt increments each cycle while the input is high.
    - Falling edge: RESULT<=cnt, set new_data, go to ARMED.
    - cnt==TIMEOUT while still high: set the timeout flag, leave RESULT unchanged, go to WAIT_LOW.
  - Disabled channel (CTRL bit 0): forced to WAIT_LOW with cnt=0. RESULT and flags are retained.
- Width rules:
  - cnt saturates at 2^CNT_W-1.
  - TIMEOUT values above 2^CNT_W-1 are truncated on write.
  - TIMEOUT=0 means no timeout; the counter saturates and the channel waits for the falling edge.
- Simultaneous events:
  - A W1C and a hardware set on the same edge: the set wins.
  - A TIMEOUT write mid-pulse takes effect on the next cycle's compare.
- Reset mid-pulse: the channel returns to WAIT_LOW. The next measured pulse must start with a full rising edge after a low.

Decomposition:
- Package apb_pwm_pkg:
  - Register offsets (CTRL_OFS, STATUS_OFS, TIMEOUT_OFS, RESULT_BASE).
  - FSM state encoding (WAIT_LOW, ARMED, HIGH).
  - STATUS bit positions.
- Sub-module pwm_width_meas, instantiated NUM_CH times by a generate loop. It holds the synchroniser, FSM, counter and result register.
- The top level holds the APB decode, CTRL/STATUS/TIMEOUT registers and read mux.

Test Plan:
- Reset, then read all registers:
  - CTRL=0, STATUS=0, TIMEOUT=2500000, RESULT=0.
  - Read of 0x00C gives PSLVERR=1, PRDATA=0.
- Enable ch0, drive a 1000-cycle high pulse: RESULT0=1000, STATUS[0]=1. Reading RESULT0 clears STATUS[0].
- Enable ch1 while its input is already high for 500 cycles, then low, then a 200-cycle pulse: only RESULT1=200 is latched.
- Write TIMEOUT=100, hold ch2 high for 300 cycles: STATUS[18]=1, RESULT2 unchanged. A following 50-cycle pulse gives RESULT2=50.
- Drive all 4 channels with pulses of 10/20/30/40 cycles ending on the same edge: each RESULT is correct and STATUS[3:0]=0xF.
- Read RESULT0 on the exact edge a new pulse (700 cycles) ends:
  - PRDATA returns the old value.
  - RESULT0=700 after the edge.
  - STATUS[0] stays 1.
- Write 0x00 to RESULT0: PSLVERR=1 and the value is unchanged.

Source files
------------

// File: rtl/apb_pwm_pkg.sv
// Shared definitions for the APB PWM width-measurement array.
package apb_pwm_pkg;

  // Register word offsets within the 4 KiB decode window
  localparam logic [11:0] CTRL_OFS    = 12'h000;
  localparam logic [11:0] STATUS_OFS  = 12'h004;
  localparam logic [11:0] TIMEOUT_OFS = 12'h008;
  localparam logic [11:0] RESULT_BASE = 12'h100;

  // STATUS field positions
  localparam int unsigned STATUS_NEW_LSB = 0;
  localparam int unsigned STATUS_TO_LSB  = 16;

  // Per-channel measurement state
  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    ARMED    = 2'd1,
    HIGH     = 2'd2
  } meas_state_t;

endpackage

// File: rtl/pwm_width_meas.sv
// One channel: input synchroniser, edge detect, high-time counter and result.
module pwm_width_meas
  import apb_pwm_pkg::*;
#(
  parameter int unsigned CNT_W = 24
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_pwm,
  input  logic [CNT_W-1:0] i_timeout,
  output logic [CNT_W-1:0] o_result,
  output logic             o_new,
  output logic             o_timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  meas_state_t      r_state;
  meas_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_result;
  logic [CNT_W-1:0] w_result_nxt;
  logic             w_rise;
  logic             w_fall;
  logic             w_new;
  logic             w_to;

  // Two-flop synchroniser plus one delayed copy for edge detection
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_pwm;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_prev;
  assign w_fall = ~r_sync2 & r_prev;

  // State, counter and result registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= WAIT_LOW;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
    end
  end

  // Next-state logic; a falling edge takes priority over a timeout compare
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    w_new        = 1'b0;
    w_to         = 1'b0;
    if (!i_en) begin
      w_state_nxt = WAIT_LOW;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        WAIT_LOW: begin
          if (!r_sync2) w_state_nxt = ARMED;
        end
        ARMED: begin
          if (w_rise) begin
            w_state_nxt = HIGH;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        HIGH: begin
          if (w_fall) begin
            w_result_nxt = r_cnt;
            w_new        = 1'b1;
            w_state_nxt  = ARMED;
          end else if ((i_timeout != '0) && (r_cnt == i_timeout)) begin
            w_to        = 1'b1;
            w_state_nxt = WAIT_LOW;
            w_cnt_nxt   = '0;
          end else if (r_cnt != CNT_MAX) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = WAIT_LOW;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign o_result  = r_result;
  assign o_new     = w_new;
  assign o_timeout = w_to;

endmodule

// File: rtl/apb_pwm_width_array.sv
// APB3 slave: register decode, CTRL/STATUS/TIMEOUT and per-channel results.
module apb_pwm_width_array
  import apb_pwm_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned DEF_TIMEOUT = 2500000
) (
  input  logic              PCLK,
  input  logic              PRESERN,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [NUM_CH-1:0] sensor_pwm
);

  logic [NUM_CH-1:0] r_ctrl;
  logic [NUM_CH-1:0] r_new;
  logic [NUM_CH-1:0] r_to;
  logic [CNT_W-1:0]  r_timeout;

  logic [11:0]       w_ofs;
  logic [11:0]       w_res_off;
  logic [9:0]        w_res_idx;
  logic              w_is_ctrl;
  logic              w_is_status;
  logic              w_is_timeout;
  logic              w_is_res;
  logic              w_access;
  logic              w_wr;
  logic              w_rd_acc;
  logic [NUM_CH-1:0] w_new_set;
  logic [NUM_CH-1:0] w_to_set;
  logic [NUM_CH-1:0] w_new_clr;
  logic [NUM_CH-1:0] w_to_clr;
  logic [NUM_CH-1:0] w_rd_clr;
  logic [31:0]       w_status;
  logic [31:0]       w_res_data;
  logic [CNT_W-1:0]  w_result [NUM_CH];
  logic              w_unused;

  // Address decode on the low 12 bits
  assign w_ofs        = PADDR[11:0];
  assign w_res_off    = w_ofs - RESULT_BASE;
  assign w_res_idx    = w_res_off[11:2];
  assign w_is_ctrl    = (w_ofs == CTRL_OFS);
  assign w_is_status  = (w_ofs == STATUS_OFS);
  assign w_is_timeout = (w_ofs == TIMEOUT_OFS);
  assign w_is_res     = (w_ofs >= RESULT_BASE) && (w_res_off[1:0] == 2'b00) &&
                        (32'(w_res_idx) < NUM_CH);

  assign w_access = PSEL & PENABLE;
  assign w_wr     = w_access & PWRITE;
  assign w_rd_acc = w_access & ~PWRITE;

  assign PREADY  = 1'b1;
  assign PSLVERR = w_access & (PWRITE ? ~(w_is_ctrl | w_is_status | w_is_timeout)
                                      : ~(w_is_ctrl | w_is_status | w_is_timeout | w_is_res));

  assign w_new_clr = ((w_wr && w_is_status) ? PWDATA[STATUS_NEW_LSB +: NUM_CH] : '0) | w_rd_clr;
  assign w_to_clr  = (w_wr && w_is_status) ? PWDATA[STATUS_TO_LSB +: NUM_CH] : '0;

  assign w_unused = ^{PADDR[31:12], PWDATA};

  // Control registers and sticky flags; hardware set wins over any clear
  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      r_ctrl    <= '0;
      r_new     <= '0;
      r_to      <= '0;
      r_timeout <= CNT_W'(DEF_TIMEOUT);
    end else begin
      if (w_wr && w_is_ctrl)    r_ctrl    <= PWDATA[NUM_CH-1:0];
      if (w_wr && w_is_timeout) r_timeout <= PWDATA[CNT_W-1:0];
      r_new <= (r_new & ~w_new_clr) | w_new_set;
      r_to  <= (r_to & ~w_to_clr) | w_to_set;
    end
  end

  // Result mux and read-to-clear of the selected channel's new_data flag
  always_comb begin
    w_rd_clr   = '0;
    w_res_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (w_is_res && (w_res_idx == 10'(i))) begin
        w_res_data  = 32'(w_result[i]);
        w_rd_clr[i] = w_rd_acc;
      end
    end
  end

  // STATUS word assembly
  always_comb begin
    w_status = '0;
    w_status[STATUS_NEW_LSB +: NUM_CH] = r_new;
    w_status[STATUS_TO_LSB +: NUM_CH]  = r_to;
  end

  // Read data; unmapped offsets return zero
  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      if (w_is_ctrl)         PRDATA = 32'(r_ctrl);
      else if (w_is_status)  PRDATA = w_status;
      else if (w_is_timeout) PRDATA = 32'(r_timeout);
      else if (w_is_res)     PRDATA = w_res_data;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_width_meas #(
      .CNT_W(CNT_W)
    ) u_meas (
      .i_clk     (PCLK),
      .i_rst_n   (PRESERN),
      .i_en      (r_ctrl[g]),
      .i_pwm     (sensor_pwm[g]),
      .i_timeout (r_timeout),
      .o_result  (w_result[g]),
      .o_new     (w_new_set[g]),
      .o_timeout (w_to_set[g])
    );
  end

endmodule
